median_n: RTL and testbench
===========================

// Module: median_n
//
// PURPOSE
// - Streaming median filter, next generation of the fixed 9-sample median: odd window depth N and data width set by parameters.
// - Sample chain, max-extraction sorter and control FSM are all inside this one block.
// - Takes a burst of samples and returns the median of the last N samples with a single-cycle strobe.
// - Sits between the pixel/sample source and downstream filtering stages. A BUSY output gives back-pressure.
//
// PARAMETERS
// - WIDTH  8  sample width in bits, >= 1.
// - N      9  window depth. Must be odd and >= 3; elaboration error otherwise.
//
// PORTS
// - CLK   in   1      clock. All logic is on the rising edge.
// - RST   in   1      synchronous, active-high reset.
// - DI    in   WIDTH  sample in, unsigned.
// - DSI   in   1      sample strobe. DI is valid while DSI=1.
// - DO    out  WIDTH  median result, registered. Holds its value until the next DSO.
// - DSO   out  1      one-cycle strobe: DO is valid and newly updated.
// - BUSY  out  1      high while computing. DSI is ignored while BUSY=1.
//
// BEHAVIOUR
// - Reset (RST=1 at an edge): state IDLE, DO=0, DSO=0, BUSY=0, all N chain registers cleared to 0, pass/cycle counters cleared to 0.
// - FSM states: IDLE -> LOAD -> PASS -> IDLE.
// - IDLE: if DSI=1, shift DI into the chain and go to LOAD.
// - LOAD: each cycle with DSI=1 shifts DI in; the oldest sample falls out. The chain always holds the last N samples.
// - LOAD exit: DSI=0 -> PASS, BUSY=1 from the next cycle.
// - Short load: if fewer than N samples were loaded, the remaining slots keep their previous contents (0 after reset) and take part in the sort.
// - PASS: P=(N+1)/2 passes, k=1..P.
//   - Each pass rotates the chain through a compare stage that keeps the running max and recirculates the smaller value.
//   - Passes 1..P-1 take N cycles each. Pass k ends by removing that pass's max (bypass slots grow by one per pass).
//   - Pass P takes P cycles. Its max is the median and is registered into DO.
//   - Duplicates: ties are compared with >=. Exactly one copy is removed per pass, so equal values count with their multiplicity.
// - Latency: L = N*(P-1)+P cycles (N=9 -> 41; N=3 -> 5), counted from the first cycle in PASS. DSO=1 for exactly 1 cycle, on the cycle DO updates. BUSY falls in that same cycle; the FSM is back in IDLE on the next edge.
// - DSI=1 while BUSY=1: the sample is dropped; chain and result are unaffected.
// - DSI=1 in the cycle after DSO: accepted normally (back-to-back operation).
// - RST during any state: immediate return to the reset values above, with no DSO. A partially computed result is discarded.
// - Arithmetic: unsigned compare only, no width growth. The counters are $clog2(N+1) bits wide; pass-cycle and pass counters saturate/wrap exactly at their limits.
//
// CONFIGURATION
// - Macro MEDIAN_N_ERR_EN.
// - Defined: adds port ERR (out, 1 bit, reset 0). ERR pulses for 1 cycle when:
//   - DSI=1 while BUSY=1; or
//   - LOAD exits after fewer than N samples since IDLE. ERR pulses on the LOAD->PASS edge; the result is still computed.
// - Undefined: no ERR port and no load counter. The other behaviour is identical.
//
// TESTING (WIDTH=8, N=9 unless stated)
// - Load 1,2,...,9, then DSI=0 -> DO=5, DSO high 41 cycles after PASS entry, for 1 cycle.
// - Load 9,200,3,3,3,7,255,0,1 -> DO=3 (duplicate handling); DO stays 3 until the next DSO.
// - Load 12 samples 100..111 -> DO=107 (only the last 9 kept). Then start another load in the cycle after DSO -> correct new median.
// - DSI=1 for 5 cycles in mid-PASS:
//   - result is unchanged and BUSY stays 1;
//   - with MEDIAN_N_ERR_EN, ERR pulses on each of those cycles.
// - RST=1 at PASS cycle 20 -> DO=0, DSO=0, BUSY=0 next cycle, no DSO afterwards. Re-load 1..9 -> DO=5.
// - N=3: load 5,1,9 -> DO=5 with latency 5. Load 4 samples after reset with MEDIAN_N_ERR_EN (N=9) -> ERR pulse on the LOAD exit edge.

Source files
------------

// File: rtl/median_n_if.sv
// Sample-in / median-out handshake bundle for median_n.
interface median_n_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DI;
    logic             DSI;
    logic [WIDTH-1:0] DO;
    logic             DSO;
    logic             BUSY;

    modport master (output DI, output DSI, input DO, input DSO, input BUSY);
    modport slave  (input DI, input DSI, output DO, output DSO, output BUSY);
endinterface

// File: rtl/median_n.sv
// Streaming median of the last N samples: sample chain, max-extraction sorter, IDLE/LOAD/PASS FSM.
// Define MEDIAN_N_ERR_EN to add the ERR pulse output (dropped sample or short load).
module median_n #(
    parameter int WIDTH = 8,
    parameter int N     = 9
) (
    input  logic      CLK,
    input  logic      RST,
`ifdef MEDIAN_N_ERR_EN
    output logic      ERR,
`endif
    median_n_if.slave bus
);
    if ((N < 3) || (N % 2 == 0) || (WIDTH < 1)) begin : g_bad_param
        $error("median_n: N must be odd and >= 3, WIDTH >= 1");
    end

    localparam int P  = (N + 1) / 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_C = CW'(N);
    localparam logic [CW-1:0] P_C = CW'(P);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PASS} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] chain_q [N];
    logic [WIDTH-1:0] chain_d [N];
    logic [WIDTH-1:0] work_q  [N];
    logic [WIDTH-1:0] work_d  [N];
    logic [WIDTH-1:0] max_q, max_d, do_q, do_d, cur;
    logic [CW-1:0]    max_idx_q, max_idx_d, cyc_q, cyc_d;
    logic [CW-1:0]    pass_q, pass_d, act_q, act_d, pass_len;
    logic             dso_q, dso_d;
    logic             accept, load_exit, final_pass, pass_last, take, done;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.DSI)  state_d = S_LOAD;
            S_LOAD:  if (!bus.DSI) state_d = S_PASS;
            S_PASS:  if (done)     state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY = (state_q == S_PASS);
        bus.DO   = do_q;
        bus.DSO  = dso_q;
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no latch can be inferred.
        chain_d   = chain_q;
        work_d    = work_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        cyc_d     = cyc_q;
        pass_d    = pass_q;
        act_d     = act_q;
        do_d      = do_q;
        dso_d     = 1'b0;

        accept     = (state_q != S_PASS) && bus.DSI;
        load_exit  = (state_q == S_LOAD) && !bus.DSI;
        final_pass = (pass_q == P_C);
        pass_len   = final_pass ? P_C : N_C;
        pass_last  = (cyc_q == pass_len - 1'b1);
        cur        = work_q[cyc_q];
        // Slots at or beyond act_q hold already-extracted maxima and are bypassed.
        take       = (cyc_q < act_q) && ((cyc_q == '0) || (cur >= max_q));
        done       = (state_q == S_PASS) && pass_last && final_pass;

        if (accept) begin
            chain_d[0] = bus.DI;
            for (int i = 1; i < N; i++) chain_d[i] = chain_q[i-1];
        end

        if (load_exit) begin
            work_d = chain_q;
            act_d  = N_C;
            pass_d = CW'(1);
            cyc_d  = '0;
        end

        if (state_q == S_PASS) begin
            if (take) begin
                max_d     = cur;
                max_idx_d = cyc_q;
            end
            if (pass_last) begin
                cyc_d = '0;
                if (final_pass) begin
                    do_d  = max_d;
                    dso_d = 1'b1;
                end else begin
                    // Drop this pass's max by moving the last live slot over it.
                    work_d[max_idx_d] = work_q[act_q - 1'b1];
                    act_d             = act_q - 1'b1;
                    pass_d            = pass_q + 1'b1;
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) chain_q[i] <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            cyc_q     <= '0;
            pass_q    <= '0;
            act_q     <= '0;
            do_q      <= '0;
            dso_q     <= 1'b0;
        end else begin
            chain_q   <= chain_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            cyc_q     <= cyc_d;
            pass_q    <= pass_d;
            act_q     <= act_d;
            do_q      <= do_d;
            dso_q     <= dso_d;
        end
    end

    // NOTE: the work array is scratch reloaded on every PASS entry, so it carries no reset.
    always_ff @(posedge CLK) begin
        work_q <= work_d;
    end

`ifdef MEDIAN_N_ERR_EN
    logic          err_q, err_d;
    logic [CW-1:0] ld_cnt_q, ld_cnt_d;

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        if (accept) begin
            if (state_q == S_IDLE)   ld_cnt_d = CW'(1);
            else if (ld_cnt_q != N_C) ld_cnt_d = ld_cnt_q + 1'b1;
        end
        err_d = ((state_q == S_PASS) && bus.DSI) || (load_exit && (ld_cnt_q < N_C));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q    <= 1'b0;
            ld_cnt_q <= '0;
        end else begin
            err_q    <= err_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    assign ERR = err_q;
`endif
endmodule

// File: tb/tb_median_n.sv
// Randomized and directed checks of median_n (N=9 and N=3) against a sorted-window reference model.
module tb_median_n;
    localparam int W  = 8;
    localparam int N9 = 9;
    localparam int N3 = 3;
    localparam int L9 = 9 * 4 + 5;
    localparam int L3 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    median_n_if #(.WIDTH(W)) b9 ();
    median_n_if #(.WIDTH(W)) b3 ();
`ifdef MEDIAN_N_ERR_EN
    logic err9, err3;
`endif

    median_n #(.WIDTH(W), .N(N9)) u_dut9 (
        .CLK (clk),
        .RST (rst),
`ifdef MEDIAN_N_ERR_EN
        .ERR (err9),
`endif
        .bus (b9)
    );

    median_n #(.WIDTH(W), .N(N3)) u_dut3 (
        .CLK (clk),
        .RST (rst),
`ifdef MEDIAN_N_ERR_EN
        .ERR (err3),
`endif
        .bus (b3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int win9[$];
    int win3[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int median_of(input int q[$]);
        int s[$];
        s = q;
        s.sort();
        return s[(s.size() - 1) / 2];
    endfunction

    task automatic reset_all();
        rst    = 1'b1;
        b9.DSI = 1'b0;
        b9.DI  = '0;
        b3.DSI = 1'b0;
        b3.DI  = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        win9 = {};
        win3 = {};
        for (int i = 0; i < N9; i++) win9.push_back(0);
        for (int i = 0; i < N3; i++) win3.push_back(0);
    endtask

    task automatic load9(input int vals[$], input string tag);
        foreach (vals[i]) begin
            b9.DI  = W'(vals[i]);
            b9.DSI = 1'b1;
            @(posedge clk);
            #1;
            win9.push_front(vals[i] & 255);
            void'(win9.pop_back());
        end
        b9.DSI = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_busy_on"}, b9.BUSY, 1);
`ifdef MEDIAN_N_ERR_EN
        check({tag, "_err_exit"}, err9, (vals.size() < N9) ? 1 : 0);
`endif
    endtask

    // Waits (bounded) for DSO; optionally pokes DSI for 'inject' cycles mid-PASS.
    task automatic pass9(input int exp, input int inject, input string tag);
        int lat;
        bit inj;
        lat = 0;
        for (int c = 1; (c <= L9 + 5) && (lat == 0); c++) begin
            inj = (inject > 0) && (c >= 10) && (c < 10 + inject);
            if (inj) begin
                b9.DI  = W'($urandom_range(0, 255));
                b9.DSI = 1'b1;
            end
            @(posedge clk);
            #1;
            b9.DSI = 1'b0;
            if (inj) begin
                check({tag, "_busy_drop"}, b9.BUSY, 1);
`ifdef MEDIAN_N_ERR_EN
                check({tag, "_err_drop"}, err9, 1);
`endif
            end
            if (b9.DSO) lat = c;
        end
        check({tag, "_latency"}, lat, L9);
        check({tag, "_do"}, b9.DO, exp);
        check({tag, "_busy_off"}, b9.BUSY, 0);
        @(posedge clk);
        #1;
        check({tag, "_dso_single"}, b9.DSO, 0);
        check({tag, "_do_hold"}, b9.DO, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int q[$];
        int lat3;
        int dso_seen;

        reset_all();
        check("rst_do", b9.DO, 0);
        check("rst_dso", b9.DSO, 0);
        check("rst_busy", b9.BUSY, 0);
        check("rst_do3", b3.DO, 0);

        q = {1, 2, 3, 4, 5, 6, 7, 8, 9};
        load9(q, "seq");
        pass9(5, 0, "seq");

        q = {9, 200, 3, 3, 3, 7, 255, 0, 1};
        load9(q, "dup");
        pass9(3, 0, "dup");
        repeat (4) @(posedge clk);
        #1 check("dup_hold_long", b9.DO, 3);

        q = {};
        for (int v = 100; v < 112; v++) q.push_back(v);
        load9(q, "long");
        pass9(107, 0, "long");
        // pass9 returns in the cycle right after DSO: back-to-back load starts here.
        q = {};
        for (int i = 0; i < N9; i++) q.push_back($urandom_range(0, 255));
        load9(q, "b2b");
        pass9(median_of(win9), 0, "b2b");

        q = {};
        for (int i = 0; i < N9; i++) q.push_back($urandom_range(0, 255));
        load9(q, "drop");
        pass9(median_of(win9), 5, "drop");

        q = {1, 2, 3, 4, 5, 6, 7, 8, 9};
        load9(q, "abort");
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_do", b9.DO, 0);
        check("abort_dso", b9.DSO, 0);
        check("abort_busy", b9.BUSY, 0);
        win9 = {};
        for (int i = 0; i < N9; i++) win9.push_back(0);
        win3 = {};
        for (int i = 0; i < N3; i++) win3.push_back(0);
        dso_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1 if (b9.DSO) dso_seen++;
        end
        check("abort_no_dso", dso_seen, 0);
        load9(q, "reload");
        pass9(5, 0, "reload");

        q = {5, 1, 9};
        foreach (q[i]) begin
            b3.DI  = W'(q[i]);
            b3.DSI = 1'b1;
            @(posedge clk);
            #1;
            win3.push_front(q[i]);
            void'(win3.pop_back());
        end
        b3.DSI = 1'b0;
        @(posedge clk);
        #1 check("n3_busy_on", b3.BUSY, 1);
        lat3 = 0;
        for (int c = 1; (c <= L3 + 5) && (lat3 == 0); c++) begin
            @(posedge clk);
            #1 if (b3.DSO) lat3 = c;
        end
        check("n3_latency", lat3, L3);
        check("n3_do", b3.DO, 5);

        reset_all();
        q = {40, 30, 20, 10};
        load9(q, "short");
        pass9(median_of(win9), 0, "short");

        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, 13);
            q = {};
            for (int i = 0; i < len; i++)
                q.push_back((t % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255));
            load9(q, $sformatf("rnd%0d", t));
            pass9(median_of(win9), (t == 3) ? 3 : 0, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
